// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register loopback sequencer.
// Optional feature macro used by the top: LOOPBACK_CHECK_EN.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Counter must reach WIDTH+DEPTH-1 without wrapping.
  function automatic int cnt_width(input int width, input int depth);
    return $clog2(width + depth);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bus of the loopback sequencer: parallel word in,
// rebuilt word and status out.
interface shift_seq_ctrl_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             mismatch;

  modport master (
    output start, data_in,
    input  ready, busy, done, data_out, mismatch
  );

  modport slave (
    input  start, data_in,
    output ready, busy, done, data_out, mismatch
  );

endinterface

// File: rtl/shift_seq_cnt.sv
// Up-counter with synchronous clear, count enable and a compare against a
// caller-supplied terminal value.
module shift_seq_cnt #(
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] count,
  output logic          at_term
);

  always_ff @(posedge clock) begin
    if (clr)
      count <= '0;
    else if (en)
      count <= count + CW'(1);
  end

  assign at_term = (count == term);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Loopback sequencer for a DEPTH-stage external shift register: clears it, streams
// a word LSB first, drains, and rebuilds the returning bits. Optional: LOOPBACK_CHECK_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clock,
  input  logic             clear,
  shift_seq_ctrl_if.slave  bus,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             sr_clear_n
);

  localparam int CW = cnt_width(WIDTH, DEPTH);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(DEPTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tx_reg, rx_reg, rx_nxt, data_out_r;
  logic [CW-1:0]    count, term;
  logic             at_term, cnt_clr, cnt_en, capture, accept, finish;
  logic             ready_c, busy_c, done_c;

  assign accept  = (state == IDLE) && bus.start;
  assign finish  = (state == DRAIN) && at_term;
  assign cnt_clr = clear || (state == CLR);
  // Hold at the last drain count so the counter never wraps inside a transfer.
  assign cnt_en  = (state == SHIFT) || ((state == DRAIN) && !at_term);
  assign term    = (state == SHIFT) ? SHIFT_LAST : DRAIN_LAST;
  assign capture = ((state == SHIFT) || (state == DRAIN)) && (count >= CAP_FIRST);
  assign rx_nxt  = {ser_in, {(WIDTH-1){1'b0}}} | (rx_reg >> 1);

  shift_seq_cnt #(.CW(CW)) u_cnt (
    .clock   (clock),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .term    (term),
    .count   (count),
    .at_term (at_term)
  );

  always_ff @(posedge clock) begin
    if (clear)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready_c    = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    ser_out    = 1'b0;
    sr_clear_n = 1'b1;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_nxt = CLR;
      end
      CLR: begin
        busy_c     = 1'b1;
        sr_clear_n = 1'b0;
        state_nxt  = SHIFT;
      end
      SHIFT: begin
        busy_c  = 1'b1;
        ser_out = tx_reg[0];
        if (at_term) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (at_term) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs show reset values for as long as clear is held.
    if (clear) begin
      ready_c    = 1'b1;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      ser_out    = 1'b0;
      sr_clear_n = 1'b0;
    end
  end

  // The final capture lands on the same edge that enters DONE, so publish rx_nxt.
  always_ff @(posedge clock) begin
    if (clear) begin
      tx_reg     <= '0;
      rx_reg     <= '0;
      data_out_r <= '0;
    end else begin
      if (accept)
        tx_reg <= bus.data_in;
      else if (state == SHIFT)
        tx_reg <= tx_reg >> 1;
      if (capture)
        rx_reg <= rx_nxt;
      if (finish)
        data_out_r <= rx_nxt;
    end
  end

`ifdef LOOPBACK_CHECK_EN
  logic [WIDTH-1:0] ref_reg;
  logic             mismatch_r;

  always_ff @(posedge clock) begin
    if (clear) begin
      ref_reg    <= '0;
      mismatch_r <= 1'b0;
    end else begin
      if (accept)
        ref_reg <= bus.data_in;
      if (finish)
        mismatch_r <= (rx_nxt != ref_reg);
    end
  end

  assign bus.mismatch = mismatch_r;
`else
  assign bus.mismatch = 1'b0;
`endif

  assign bus.ready    = ready_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.data_out = data_out_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (8x4 and 2x1) each closed through a
// behavioural shift register, with scoreboards checked on done.
module tb_shift_seq_ctrl;

  localparam int W = 8;
  localparam int D = 4;
`ifdef LOOPBACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] word;
    int         flip_bit;
    int         pulse_at;
    logic [7:0] exp_data;
    logic       exp_mis;
  } vec_t;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl_if #(.WIDTH(W)) bus ();
  logic         ser_out, ser_in, sr_clear_n, inject;
  logic [D-1:0] sr;

  shift_seq_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clock      (clock),
    .clear      (clear),
    .bus        (bus),
    .ser_out    (ser_out),
    .ser_in     (ser_in),
    .sr_clear_n (sr_clear_n)
  );

  always @(posedge clock) begin
    if (!sr_clear_n) sr <= '0;
    else             sr <= {sr[D-2:0], ser_out};
  end
  assign ser_in = sr[D-1] ^ inject;

  shift_seq_ctrl_if #(.WIDTH(2)) bus2 ();
  logic ser_out2, ser_in2, sr_clear_n2, sr2;

  shift_seq_ctrl #(.WIDTH(2), .DEPTH(1)) dut2 (
    .clock      (clock),
    .clear      (clear),
    .bus        (bus2),
    .ser_out    (ser_out2),
    .ser_in     (ser_in2),
    .sr_clear_n (sr_clear_n2)
  );

  always @(posedge clock) sr2 <= sr_clear_n2 ? ser_out2 : 1'b0;
  assign ser_in2 = sr2;

  logic [8:0] exp_q[$];
  logic [2:0] exp_q2[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  always @(negedge clock) begin : mon_big
    logic [8:0] e;
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) failNow("unexpected_done");
      else begin
        e = exp_q.pop_front();
        checkOutput("data_out", 32'(bus.data_out), 32'(e[8:1]));
        checkOutput("mismatch", 32'(bus.mismatch), 32'(e[0]));
      end
    end
  end

  always @(negedge clock) begin : mon_small
    logic [2:0] e;
    if (bus2.done === 1'b1) begin
      if (exp_q2.size() == 0) failNow("small_unexpected_done");
      else begin
        e = exp_q2.pop_front();
        checkOutput("small_data_out", 32'(bus2.data_out), 32'(e[2:1]));
        checkOutput("small_mismatch", 32'(bus2.mismatch), 32'(e[0]));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] word, input int flip_bit, input int pulse_at,
                               input logic [7:0] exp_data, input logic exp_mis);
    int  n;
    bit  got;
    logic exp_ser;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start   = 1'b1;
    bus.data_in = word;
    exp_q.push_back({exp_data, exp_mis});
    @(posedge clock); #1;
    bus.start   = 1'b0;
    bus.data_in = 8'($urandom);
    checkOutput("ready_after_accept", 32'(bus.ready), 32'd0);
    checkOutput("busy_in_clr", 32'(bus.busy), 32'd1);
    checkOutput("sr_clear_n_in_clr", 32'(sr_clear_n), 32'd0);
    got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      inject = (flip_bit >= 0) && (i == flip_bit + D + 1);
      bus.start = (i == pulse_at);
      if (i == pulse_at) bus.data_in = 8'h00;
      if (bus.done === 1'b1) begin
        got = 1'b1;
        checkOutput("latency", 32'(i), 32'(W + D + 1));
        checkOutput("ready_in_done", 32'(bus.ready), 32'd0);
        checkOutput("busy_in_done", 32'(bus.busy), 32'd0);
        break;
      end else if (i <= W + D) begin
        exp_ser = (i <= W) ? word[i-1] : 1'b0;
        checkOutput("ser_out", 32'(ser_out), 32'(exp_ser));
        checkOutput("busy_in_transfer", 32'(bus.busy), 32'd1);
        checkOutput("sr_clear_n_in_transfer", 32'(sr_clear_n), 32'd1);
      end
    end
    inject    = 1'b0;
    bus.start = 1'b0;
    if (!got) failNow("done_timeout");
  endtask

  task automatic applyStimulus2(input logic [1:0] word);
    int n;
    bit got;
    n = 0;
    while (bus2.ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    bus2.start   = 1'b1;
    bus2.data_in = word;
    exp_q2.push_back({word, 1'b0});
    @(posedge clock); #1;
    bus2.start = 1'b0;
    got = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (bus2.done === 1'b1) begin
        got = 1'b1;
        checkOutput("small_latency", 32'(i), 32'd4);
        break;
      end
    end
    if (!got) failNow("small_done_timeout");
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA5, -1, -1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, -1, -1, 8'h3C, 1'b0};
    vecs[2] = '{8'hFF, -1, -1, 8'hFF, 1'b0};
    vecs[3] = '{8'h66, -1,  3, 8'h66, 1'b0};
    vecs[4] = '{8'h80,  7, -1, 8'h00, CHK};
    vecs[5] = '{8'h01, -1, -1, 8'h01, 1'b0};
    vecs[6] = '{8'h0F,  2, -1, 8'h0B, CHK};

    clear        = 1'b1;
    inject       = 1'b0;
    bus.start    = 1'b0;
    bus.data_in  = '0;
    bus2.start   = 1'b0;
    bus2.data_in = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_ready", 32'(bus.ready), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_ser_out", 32'(ser_out), 32'd0);
    checkOutput("reset_sr_clear_n", 32'(sr_clear_n), 32'd0);
    checkOutput("reset_data_out", 32'(bus.data_out), 32'd0);
    checkOutput("reset_mismatch", 32'(bus.mismatch), 32'd0);
    checkOutput("small_reset_ready", 32'(bus2.ready), 32'd1);
    clear = 1'b0;
    @(posedge clock); #1;
    checkOutput("idle_ready", 32'(bus.ready), 32'd1);
    checkOutput("idle_sr_clear_n", 32'(sr_clear_n), 32'd1);

    for (int v = 0; v < 7; v++)
      applyStimulus(vecs[v].word, vecs[v].flip_bit, vecs[v].pulse_at,
                    vecs[v].exp_data, vecs[v].exp_mis);

    // Abort at counter 5: no done may follow, outputs back to reset values.
    @(posedge clock); #1;
    bus.start   = 1'b1;
    bus.data_in = 8'h5A;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("busy_before_clear", 32'(bus.busy), 32'd1);
    clear = 1'b1;
    #1;
    checkOutput("clear_ready", 32'(bus.ready), 32'd1);
    checkOutput("clear_busy", 32'(bus.busy), 32'd0);
    checkOutput("clear_ser_out", 32'(ser_out), 32'd0);
    checkOutput("clear_sr_clear_n", 32'(sr_clear_n), 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    checkOutput("post_clear_ready", 32'(bus.ready), 32'd1);
    checkOutput("post_clear_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_clear_done", 32'(bus.done), 32'd0);
    checkOutput("post_clear_ser_out", 32'(ser_out), 32'd0);
    checkOutput("post_clear_data_out", 32'(bus.data_out), 32'd0);
    checkOutput("post_clear_mismatch", 32'(bus.mismatch), 32'd0);
    repeat (20) @(posedge clock);
    #1;
    checkOutput("post_clear_still_idle", 32'(bus.ready), 32'd1);
    applyStimulus(8'h81, -1, -1, 8'h81, 1'b0);

    applyStimulus2(2'b10);
    applyStimulus2(2'b01);
    applyStimulus2(2'b11);

    repeat (3) @(posedge clock);
    #1;
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("small_scoreboard_empty", 32'(exp_q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
